wm_console: RTL and testbench
=============================

# wm_console

Front-panel console controller for the washing-machine FSM. It debounces the user's start and pause buttons and qualifies mains power, then drives the machine's `cycle` and `supply` inputs. It also consumes the machine's `stage` output to time each stage, detect completion and detect stalls or illegal codes. It sits between the panel I/O and `washing_machine`, closing the loop the machine leaves open.

## Interface
- `DEBOUNCE_CYC`, default 16: consecutive stable synchronized samples required to accept a button level change (min 1).
- `STAGE_TIMEOUT`, default 200: max cycles a non-idle, non-done stage may persist with supply on before a fault.
- `BEEP_CYC`, default 32: length of the completion beep pulse in cycles.
- `clk  in  1`: system clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `start_btn  in  1`: raw start/acknowledge button, asynchronous, active high.
- `pause_btn  in  1`: raw pause/resume toggle button, asynchronous, active high.
- `mains_ok  in  1`: mains-present indication, synchronous to `clk`.
- `stage  in  3`: machine stage. Encoding: 000 idle, 001 fill, 010 wash, 011 rinse, 100 spin, 101 done; 110 and 111 are illegal.
- `cycle  out  1`: cycle-run request to the machine.
- `supply  out  1`: power enable to the machine.
- `beep  out  1`: completion buzzer.
- `fault  out  1`: sticky fault flag.
- `stage_time  out  8`: cycles spent in the current stage, saturating at 255.
- `state_led  out  3`: console state code, listed under Operation.

## Operation
- Button paths:
  - Each button passes through a 2-FF synchronizer, then a debounce counter.
  - The counter clears whenever the synchronized level differs from the accepted level.
  - When the counter reaches `DEBOUNCE_CYC`, the accepted level updates.
  - A rising edge of the accepted level produces a one-cycle press pulse.
- Console states, with `state_led` codes:
  - IDLE 000: `cycle=0`. Start press moves to RUN.
  - RUN 001: `cycle=1`.
    - Pause press moves to PAUSE.
    - `stage==101` moves to DONE.
    - An illegal stage or a watchdog expiry moves to FAULT.
  - PAUSE 010: `cycle=1`, `supply=0`. The machine retains its stage.
    - Pause press moves to RUN.
    - Start press is ignored.
  - DONE 011: `beep` is high for `BEEP_CYC` cycles after entry. A start press (acknowledge) moves to IDLE.
  - FAULT 100: `cycle=0`, `supply=0`, `fault=1`. Only `rst` exits this state.
- `supply` equals `mains_ok` in IDLE, RUN and DONE; it is 0 in PAUSE and FAULT.
- Mains loss in RUN:
  - No state change; `supply` follows `mains_ok` low.
  - The watchdog and `stage_time` hold while `supply=0`.
- `stage_time`:
  - Clears to 0 on any change of `stage`.
  - Increments by 1 each cycle that `supply=1`.
  - Saturates at 255.
- Watchdog:
  - Uses its own counter, of width clog2(`STAGE_TIMEOUT`+1), with the same clear and hold rules as `stage_time`.
  - It is active only in RUN with stage 001–100.
  - The watchdog fires when the counter equals `STAGE_TIMEOUT`.
- Simultaneous events in the same cycle:
  - In RUN, priority is: illegal stage, then watchdog, then `stage==101`, then pause press.
  - In RUN, a start press is ignored.
  - Start and pause pressed together in IDLE: start wins and the pause press is dropped.
- Reset, asserted at any time:
  - All outputs go to 0 asynchronously; state returns to IDLE.
  - The synchronizers, debounce counters and accepted levels clear to 0. A button held through reset must therefore be re-qualified and produces a press.

## Timing
- All outputs are registered.
- Press latency:
  - A button high is first sampled at edge k.
  - The press pulse is internal at edge k+1+`DEBOUNCE_CYC`.
  - State and outputs change at edge k+2+`DEBOUNCE_CYC`.
- Stage-driven transitions (done, illegal, stage change to `stage_time`) update outputs at the edge after `stage` is sampled, giving 1-cycle latency.
- `supply` follows `mains_ok` with 1-cycle latency.
- `beep` rises in the same cycle DONE is entered and is high for exactly `BEEP_CYC` cycles. Leaving DONE early (ack) drops `beep` with the state change.
- Glitches shorter than `DEBOUNCE_CYC` synchronized cycles produce no press.

## Configuration
- `WM_CONSOLE_WATCHDOG_EN`:
  - Defined: the watchdog counter and the transition to FAULT are compiled in.
  - Undefined: no watchdog logic; FAULT is reachable only via an illegal stage code.
  - `stage_time` is present in both builds.

## Test plan
Use `DEBOUNCE_CYC=4`, `STAGE_TIMEOUT=20` and `BEEP_CYC=8`.
- Normal cycle:
  - Stimulus: `mains_ok=1`; start held 10 cycles; model steps `stage` 001→010→011→100→101 every 10 cycles.
  - Required: `cycle=1` at 6 cycles after the first sampled press; `stage_time` reaches 9 then clears; DONE entered with `beep` high for exactly 8 cycles; start press returns to IDLE with `cycle=0`.
- Bounce:
  - Stimulus: start toggles every 2 cycles for 20 cycles, then goes low.
  - Required: state stays IDLE and `cycle=0`.
- Pause and mains loss:
  - Pause in RUN: `supply=0`, `state_led=010`, `stage_time` frozen.
  - Second pause: back to RUN, counting resumes.
  - `mains_ok` low for 30 cycles in RUN: no FAULT, with the watchdog built in.
- Watchdog:
  - Stimulus: `stage` held at 010 with `supply=1` for 21 cycles.
  - Required: FAULT, `fault=1`, `cycle=0`, `supply=0`; a start press has no effect.
  - Without `WM_CONSOLE_WATCHDOG_EN`: remains in RUN and `stage_time` saturates at 255.
- Illegal code: `stage=111` in RUN → FAULT on the next edge, taking priority over a pause press in the same cycle.
- Reset mid-cycle: assert `rst` in PAUSE → all outputs 0 immediately; after release, state is IDLE.

Source files
------------

// File: rtl/wm_console.sv
// rtl/wm_console.sv - panel console for the washing machine: debounce, run/pause/done/fault control, stage timing
// Define WM_CONSOLE_WATCHDOG_EN to compile in the per-stage watchdog.
module wm_console #(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int STAGE_TIMEOUT = 200,
  parameter int BEEP_CYC      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       mains_ok,
  input  logic [2:0] stage,
  output logic       cycle,
  output logic       supply,
  output logic       beep,
  output logic       fault,
  output logic [7:0] stage_time,
  output logic [2:0] state_led
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int BW = $clog2(BEEP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_RUN   = 3'b001,
    S_PAUSE = 3'b010,
    S_DONE  = 3'b011,
    S_FAULT = 3'b100
  } state_t;

  state_t state, nxt;

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       start_press;
  logic       pause_press;

  assign btn_raw     = {pause_btn, start_btn};
  assign start_press = press[0];
  assign pause_press = press[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          s1, s2, acc, pr;
      logic [DW-1:0] cnt;

      // Accepted level moves only after DEBOUNCE_CYC consecutive differing samples.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1  <= 1'b0;
          s2  <= 1'b0;
          acc <= 1'b0;
          pr  <= 1'b0;
          cnt <= '0;
        end else begin
          s1 <= btn_raw[gi];
          s2 <= s1;
          pr <= 1'b0;
          if (s2 == acc) begin
            cnt <= '0;
          end else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
            cnt <= '0;
            acc <= s2;
            pr  <= s2;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
      end

      assign press[gi] = pr;
    end
  endgenerate

  logic [2:0] stage_q;
  logic       stage_chg;
  logic       illegal;
  logic       active_stage;
  logic       wd_fire;

  assign stage_chg    = (stage != stage_q);
  assign illegal      = stage[2] & stage[1];
  assign active_stage = (stage != 3'b000) && (stage <= 3'b100);

`ifdef WM_CONSOLE_WATCHDOG_EN
  localparam int WW = $clog2(STAGE_TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // Counts only while the machine is powered and running a working stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (stage_chg || state == S_IDLE) begin
      wd_cnt <= '0;
    end else if (state == S_RUN && active_stage && supply &&
                 wd_cnt != WW'(STAGE_TIMEOUT)) begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end

  assign wd_fire = (state == S_RUN) && active_stage && (wd_cnt == WW'(STAGE_TIMEOUT));
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q    <= 3'b000;
      stage_time <= 8'd0;
    end else begin
      stage_q <= stage;
      if (stage_chg) begin
        stage_time <= 8'd0;
      end else if (supply && stage_time != 8'hff) begin
        stage_time <= stage_time + 8'd1;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start_press) nxt = S_RUN;
      S_RUN: begin
        if (illegal)               nxt = S_FAULT;
        else if (wd_fire)          nxt = S_FAULT;
        else if (stage == 3'b101)  nxt = S_DONE;
        else if (pause_press)      nxt = S_PAUSE;
      end
      S_PAUSE: if (pause_press) nxt = S_RUN;
      S_DONE:  if (start_press) nxt = S_IDLE;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  logic [BW-1:0] beep_cnt;

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cycle    <= 1'b0;
      supply   <= 1'b0;
      fault    <= 1'b0;
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else begin
      state  <= nxt;
      cycle  <= (nxt == S_RUN) || (nxt == S_PAUSE) || (nxt == S_DONE);
      supply <= mains_ok && ((nxt == S_IDLE) || (nxt == S_RUN) || (nxt == S_DONE));
      fault  <= (nxt == S_FAULT);
      if (nxt == S_DONE && state != S_DONE) begin
        beep     <= 1'b1;
        beep_cnt <= BW'(BEEP_CYC - 1);
      end else if (nxt == S_DONE && beep_cnt != '0) begin
        beep_cnt <= beep_cnt - BW'(1);
      end else begin
        beep     <= 1'b0;
        beep_cnt <= '0;
      end
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_wm_console.sv
// tb/tb_wm_console.sv - directed self-checking bench for wm_console
module tb_wm_console;

  localparam int DEB  = 4;
  localparam int TMO  = 20;
  localparam int BEEP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       mains_ok = 1'b1;
  logic [2:0] stage = 3'b000;
  logic       cycle, supply, beep, fault;
  logic [7:0] stage_time;
  logic [2:0] state_led;

  int checks = 0;
  int errors = 0;

  wm_console #(
    .DEBOUNCE_CYC (DEB),
    .STAGE_TIMEOUT(TMO),
    .BEEP_CYC     (BEEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .mains_ok  (mains_ok),
    .stage     (stage),
    .cycle     (cycle),
    .supply    (supply),
    .beep      (beep),
    .fault     (fault),
    .stage_time(stage_time),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_btn = 1'b1;
    repeat (10) tick();
    start_btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    stage = 3'b000;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    mains_ok = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if ({cycle, supply, beep, fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cycle, supply, beep, fault}); end
    checks++; if (stage_time !== 8'd0) begin errors++; $display("FAIL reset_stage_time: got %0d expected 0", stage_time); end
    checks++; if (state_led !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", state_led); end
    rst = 1'b0;
    tick();
    checks++; if (supply !== 1'b1) begin errors++; $display("FAIL idle_supply: got %b expected 1", supply); end
    checks++; if (cycle !== 1'b0) begin errors++; $display("FAIL idle_cycle: got %b expected 0", cycle); end
  endtask

  task automatic test_normal_cycle();
    int n;
    start_btn = 1'b1;
    repeat (6) tick();
    checks++; if (cycle !== 1'b0) begin errors++; $display("FAIL press_early: cycle=%b expected 0", cycle); end
    tick();
    checks++; if (cycle !== 1'b1 || state_led !== 3'b001) begin errors++; $display("FAIL press_latency: cycle=%b state=%b expected 1/001", cycle, state_led); end
    repeat (3) tick();
    start_btn = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      stage = 3'(s);
      tick();
      checks++; if (stage_time !== 8'd0) begin errors++; $display("FAIL stage_clear_%0d: got %0d expected 0", s, stage_time); end
      repeat (9) tick();
      checks++; if (stage_time !== 8'd9) begin errors++; $display("FAIL stage_count_%0d: got %0d expected 9", s, stage_time); end
    end
    stage = 3'b101;
    tick();
    checks++; if (state_led !== 3'b011 || beep !== 1'b1) begin errors++; $display("FAIL done_entry: state=%b beep=%b expected 011/1", state_led, beep); end
    n = 1;
    repeat (12) begin
      tick();
      if (beep) n++;
    end
    checks++; if (n != BEEP) begin errors++; $display("FAIL beep_length: got %0d expected %0d", n, BEEP); end
    start_btn = 1'b1;
    repeat (6) tick();
    checks++; if (state_led !== 3'b011) begin errors++; $display("FAIL ack_early: state=%b expected 011", state_led); end
    tick();
    checks++; if (state_led !== 3'b000 || cycle !== 1'b0) begin errors++; $display("FAIL ack_idle: state=%b cycle=%b expected 000/0", state_led, cycle); end
    repeat (3) tick();
    start_btn = 1'b0;
    repeat (8) tick();
    stage = 3'b000;
    tick();
  endtask

  task automatic test_bounce();
    repeat (5) begin
      start_btn = 1'b1;
      repeat (2) tick();
      start_btn = 1'b0;
      repeat (2) tick();
    end
    repeat (10) tick();
    checks++; if (state_led !== 3'b000 || cycle !== 1'b0) begin errors++; $display("FAIL bounce: state=%b cycle=%b expected 000/0", state_led, cycle); end
  endtask

  task automatic test_pause_mains();
    do_start();
    stage = 3'b010;
    tick();
    repeat (3) tick();
    pause_btn = 1'b1;
    repeat (6) tick();
    checks++; if (state_led !== 3'b001) begin errors++; $display("FAIL pause_early: state=%b expected 001", state_led); end
    tick();
    checks++; if (state_led !== 3'b010 || supply !== 1'b0 || cycle !== 1'b1) begin errors++; $display("FAIL pause_enter: state=%b supply=%b cycle=%b expected 010/0/1", state_led, supply, cycle); end
    checks++; if (stage_time !== 8'd10) begin errors++; $display("FAIL pause_time: got %0d expected 10", stage_time); end
    repeat (3) tick();
    pause_btn = 1'b0;
    repeat (8) tick();
    checks++; if (stage_time !== 8'd10) begin errors++; $display("FAIL pause_frozen: got %0d expected 10", stage_time); end
    pause_btn = 1'b1;
    repeat (7) tick();
    checks++; if (state_led !== 3'b001 || supply !== 1'b1 || stage_time !== 8'd10) begin errors++; $display("FAIL resume: state=%b supply=%b time=%0d expected 001/1/10", state_led, supply, stage_time); end
    repeat (3) tick();
    pause_btn = 1'b0;
    checks++; if (stage_time !== 8'd13) begin errors++; $display("FAIL resume_count: got %0d expected 13", stage_time); end
    stage = 3'b011;
    tick();
    mains_ok = 1'b0;
    tick();
    repeat (29) tick();
    checks++; if (state_led !== 3'b001 || fault !== 1'b0 || supply !== 1'b0) begin errors++; $display("FAIL mains_loss: state=%b fault=%b supply=%b expected 001/0/0", state_led, fault, supply); end
    checks++; if (stage_time !== 8'd1) begin errors++; $display("FAIL mains_hold: got %0d expected 1", stage_time); end
    mains_ok = 1'b1;
    repeat (2) tick();
    checks++; if (supply !== 1'b1 || stage_time !== 8'd2) begin errors++; $display("FAIL mains_back: supply=%b time=%0d expected 1/2", supply, stage_time); end
  endtask

  task automatic test_illegal();
    pause_btn = 1'b1;
    repeat (6) tick();
    stage = 3'b111;
    checks++; if (state_led !== 3'b001) begin errors++; $display("FAIL illegal_pre: state=%b expected 001", state_led); end
    tick();
    checks++; if (state_led !== 3'b100 || fault !== 1'b1 || cycle !== 1'b0 || supply !== 1'b0) begin errors++; $display("FAIL illegal_fault: state=%b fault=%b cycle=%b supply=%b expected 100/1/0/0", state_led, fault, cycle, supply); end
    repeat (3) tick();
    pause_btn = 1'b0;
    repeat (8) tick();
    stage = 3'b010;
    do_start();
    checks++; if (state_led !== 3'b100 || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: state=%b fault=%b expected 100/1", state_led, fault); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    do_start();
    stage = 3'b010;
    tick();
    repeat (TMO) tick();
    checks++; if (state_led !== 3'b001 || stage_time !== 8'(TMO)) begin errors++; $display("FAIL wd_pre: state=%b time=%0d expected 001/%0d", state_led, stage_time, TMO); end
    tick();
`ifdef WM_CONSOLE_WATCHDOG_EN
    checks++; if (state_led !== 3'b100 || fault !== 1'b1 || cycle !== 1'b0 || supply !== 1'b0) begin errors++; $display("FAIL wd_fault: state=%b fault=%b cycle=%b supply=%b expected 100/1/0/0", state_led, fault, cycle, supply); end
    do_start();
    checks++; if (state_led !== 3'b100) begin errors++; $display("FAIL wd_start_ignored: state=%b expected 100", state_led); end
`else
    checks++; if (state_led !== 3'b001 || fault !== 1'b0) begin errors++; $display("FAIL nowd_run: state=%b fault=%b expected 001/0", state_led, fault); end
    repeat (240) tick();
    checks++; if (stage_time !== 8'd255 || state_led !== 3'b001) begin errors++; $display("FAIL nowd_saturate: time=%0d state=%b expected 255/001", stage_time, state_led); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_start();
    stage = 3'b001;
    pause_btn = 1'b1;
    repeat (10) tick();
    pause_btn = 1'b0;
    repeat (8) tick();
    checks++; if (state_led !== 3'b010) begin errors++; $display("FAIL mid_pause: state=%b expected 010", state_led); end
    start_btn = 1'b1;
    rst = 1'b1;
    #2;
    checks++; if ({cycle, supply, beep, fault} !== 4'b0000 || stage_time !== 8'd0 || state_led !== 3'b000) begin errors++; $display("FAIL mid_reset_async: flags=%b time=%0d state=%b expected 0000/0/000", {cycle, supply, beep, fault}, stage_time, state_led); end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++; if (state_led !== 3'b000 || cycle !== 1'b0) begin errors++; $display("FAIL mid_idle: state=%b cycle=%b expected 000/0", state_led, cycle); end
    tick();
    checks++; if (state_led !== 3'b001) begin errors++; $display("FAIL held_requalify: state=%b expected 001", state_led); end
    start_btn = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_bounce();
    test_pause_mains();
    test_illegal();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
